// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the multi-cycle byte data memory.
// The FSM states, the latched request and the latency/depth defaults live here.
package data_mem_pkg;

  localparam int unsigned ACCESS_CYCLES_DEF = 5;
  localparam int unsigned DEPTH_DEF         = 256;
  localparam int unsigned ADDR_W            = 8;
  localparam int unsigned DATA_W            = 8;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // A request is only accepted when exactly one of read/write is asserted.
  function automatic logic is_request(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Counts ACCESS-state cycles; tc marks the last cycle of the access window.
// clear has priority over enable so the count always starts from zero.
module mem_latency_counter
  import data_mem_pkg::*;
#(
  parameter int unsigned TERMINAL = ACCESS_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable)
      count <= count + CNT_W'(1);
  end

  assign tc = enable && (count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/data_memory.sv
// Byte-wide data memory with a fixed multi-cycle access latency and a CPU stall.
// IDLE accepts one request, ACCESS waits ACCESS_CYCLES cycles, DONE drops the stall.
module data_memory
  import data_mem_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int unsigned DEPTH         = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state;
  mem_req_t         req_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic             commit;
  logic [DATA_W-1:0] mem [DEPTH];

  mem_latency_counter #(
    .TERMINAL (ACCESS_CYCLES)
  ) u_lat (
    .clk    (CLK),
    .rst    (RESET),
    .clear  (state == IDLE),
    .enable (state == ACCESS),
    .count  (cnt),
    .tc     (cnt_tc)
  );

  logic unused_cnt;
  assign unused_cnt = ^cnt;

  assign commit = (state == ACCESS) && cnt_tc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      READDATA <= '0;
      req_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_request(READ, WRITE)) begin
            req_q <= '{is_write: WRITE, addr: ADDRESS, wdata: WRITEDATA};
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_tc) begin
            if (!req_q.is_write)
              READDATA <= mem[req_q.addr[AW-1:0]];
            state <= DONE;
          end
        end
        // Return to IDLE regardless of inputs so a held request is not re-taken here.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array kept out of the reset branch: contents survive reset, aborted writes never land.
  always_ff @(posedge CLK) begin
    if (!RESET && commit && req_q.is_write)
      mem[req_q.addr[AW-1:0]] <= req_q.wdata;
  end

  assign BUSYWAIT = !RESET &&
                    (((state == IDLE) && is_request(READ, WRITE)) || (state == ACCESS));

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: transaction-level model plus directed vectors.
module tb_data_memory;

  localparam int AC = 5;

  logic       CLK = 1'b0;
  logic       RESET, READ, WRITE;
  logic [7:0] ADDRESS, WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  int checks = 0;
  int failures = 0;

  data_memory #(.ACCESS_CYCLES(AC), .DEPTH(256)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
    .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Model: a transaction is remaining stall cycles plus a one-cycle done window.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  int         m_left = 0;
  bit         m_done = 0;
  bit         m_wr;
  logic [7:0] m_addr, m_data;
  logic [7:0] m_rd = 8'h00;
  bit         m_rd_known = 0;
  bit         chk_en = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_left = 0; m_done = 0; m_rd = 8'h00; m_rd_known = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        if (m_wr) begin
          m_mem[m_addr] = m_data; m_known[m_addr] = 1;
        end else begin
          m_rd = m_mem[m_addr]; m_rd_known = m_known[m_addr];
        end
      end
    end else if (READ ^ WRITE) begin
      m_wr = WRITE; m_addr = ADDRESS; m_data = WRITEDATA; m_left = AC;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      bit exp_busy;
      exp_busy = !RESET && (m_left > 0 || (!m_done && (READ ^ WRITE)));
      checks++;
      if (BUSYWAIT !== exp_busy) begin
        failures++;
        $display("FAIL model_busywait t=%0t got=%b want=%b", $time, BUSYWAIT, exp_busy);
      end
      if (m_rd_known) begin
        checks++;
        if (READDATA !== m_rd) begin
          failures++;
          $display("FAIL model_readdata t=%0t got=%h want=%h", $time, READDATA, m_rd);
        end
      end
    end
  end

  task automatic check8(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Issues one request at posedge+1, counts stalled cycles; returns in DONE with READDATA.
  // chg_at > 0 rewrites ADDRESS/WRITEDATA after that many stalled cycles.
  task automatic do_op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input int chg_at, input logic [7:0] chg_a,
                       output int stall, output logic [7:0] rd);
    bit done = 0;
    @(posedge CLK); #1;
    READ = !wr; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    stall = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (BUSYWAIT) begin
        stall++;
        if (stall == chg_at) begin
          #1; ADDRESS = chg_a; WRITEDATA = ~d;
        end
      end else done = 1;
    end
    rd = READDATA;
    if (!done) check8("op_timeout", 0, 1);
    #1; READ = 0; WRITE = 0;
  endtask

  int stall;
  logic [7:0] rd;
  logic [9:0] pat;

  initial begin
    RESET = 1; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
    @(posedge CLK); #1;
    chk_en = 1;
    @(posedge CLK); #1;
    RESET = 0;
    check8("reset_readdata", READDATA, 8'h00);
    check8("reset_busy", BUSYWAIT, 0);

    // Write A5 to 10 then read it back; both stall AC+1 cycles.
    do_op(1, 8'h10, 8'hA5, 0, 0, stall, rd);
    check8("wr10_stall", stall, 6);
    check8("wr_keeps_readdata", rd, 8'h00);
    do_op(0, 8'h10, 8'h00, 0, 0, stall, rd);
    check8("rd10_stall", stall, 6);
    check8("rd10_data", rd, 8'hA5);

    // Held READ: one transaction, one DONE gap, then a fresh request.
    do_op(1, 8'h03, 8'h77, 0, 0, stall, rd);
    @(posedge CLK); #1;
    READ = 1; ADDRESS = 8'h03;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); pat[9-i] = BUSYWAIT;
    end
    #1; READ = 0;
    check8("held_read_pattern", pat, 10'b1111110111);
    check8("held_read_data", READDATA, 8'h77);
    for (int i = 0; i < 40 && BUSYWAIT; i++) @(negedge CLK);
    check8("held_read_drain", BUSYWAIT, 0);

    // Reset in the 3rd ACCESS cycle aborts a pending write.
    do_op(1, 8'h20, 8'h00, 0, 0, stall, rd);
    @(posedge CLK); #1;
    WRITE = 1; ADDRESS = 8'h20; WRITEDATA = 8'h5A;
    repeat (4) @(negedge CLK);
    #1; RESET = 1; WRITE = 0;
    #1; check8("busy_in_reset", BUSYWAIT, 0);
    @(negedge CLK); #1;
    check8("readdata_after_reset", READDATA, 8'h00);
    RESET = 0;
    do_op(0, 8'h20, 8'h00, 0, 0, stall, rd);
    check8("aborted_write_data", rd, 8'h00);

    // READ and WRITE together is not a request.
    do_op(1, 8'h07, 8'h3C, 0, 0, stall, rd);
    @(posedge CLK); #1;
    READ = 1; WRITE = 1; ADDRESS = 8'h07; WRITEDATA = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); check8("both_busy", BUSYWAIT, 0);
    end
    #1; READ = 0; WRITE = 0;
    do_op(0, 8'h07, 8'h00, 0, 0, stall, rd);
    check8("both_mem_unchanged", rd, 8'h3C);

    // Address change mid-ACCESS is ignored.
    do_op(1, 8'h04, 8'h11, 0, 0, stall, rd);
    do_op(1, 8'h05, 8'h22, 0, 0, stall, rd);
    do_op(0, 8'h04, 8'h00, 2, 8'h05, stall, rd);
    check8("addr_change_data", rd, 8'h11);
    check8("addr_change_stall", stall, 6);

    // Top address then address 0.
    do_op(1, 8'h00, 8'h00, 0, 0, stall, rd);
    do_op(1, 8'hFF, 8'hFF, 0, 0, stall, rd);
    do_op(0, 8'hFF, 8'h00, 0, 0, stall, rd);
    check8("top_addr_data", rd, 8'hFF);
    do_op(0, 8'h00, 8'h00, 0, 0, stall, rd);
    check8("addr0_data", rd, 8'h00);

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter ACCESS_CYCLES SHALL have default 5; it is the number of ACCESS-state cycles per transaction, legal range 1..15.
REQ-002 Parameter DEPTH SHALL have default 256; it is the number of byte locations, addressed 0..DEPTH-1.
REQ-003 Port CLK SHALL be an input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port RESET SHALL be an input, 1 bit: synchronous active-high reset.
REQ-005 Port READ SHALL be an input, 1 bit: read request from the CPU.
REQ-006 Port WRITE SHALL be an input, 1 bit: write request from the CPU.
REQ-007 Port ADDRESS SHALL be an input, 8 bits: byte address.
REQ-008 Port WRITEDATA SHALL be an input, 8 bits: store data.
REQ-009 Port READDATA SHALL be an output, 8 bits, registered: load data.
REQ-010 Port BUSYWAIT SHALL be an output, 1 bit: stall to the CPU; high means the CPU must hold its PC and register writes.

Function
REQ-011 The block SHALL implement states IDLE, ACCESS and DONE.
REQ-012 In IDLE, exactly one of READ and WRITE high SHALL be a request; at the next edge the block SHALL latch ADDRESS, WRITEDATA and the op, clear the counter, and enter ACCESS.
REQ-013 BUSYWAIT SHALL equal (state==IDLE && (READ xor WRITE)) || state==ACCESS. It is combinational in IDLE, so the request cycle is already stalled.
REQ-014 ACCESS SHALL last exactly ACCESS_CYCLES cycles; the counter increments each cycle, and on the edge where counter==ACCESS_CYCLES-1 the block SHALL enter DONE.
REQ-015 On the ACCESS->DONE edge, a read SHALL load READDATA from mem[latched address], and a write SHALL commit the latched WRITEDATA to mem[latched address].
REQ-016 DONE SHALL last one cycle with BUSYWAIT low and then SHALL return unconditionally to IDLE, even if READ or WRITE is still high. This prevents re-triggering on the CPU's stale request.
REQ-017 Total stall SHALL be ACCESS_CYCLES+1 cycles (request cycle plus ACCESS); READDATA SHALL be valid in the DONE cycle.
REQ-018 READDATA SHALL hold its value until the next read completes; writes SHALL NOT change READDATA.
REQ-019 Changes on ADDRESS, WRITEDATA, READ or WRITE during ACCESS or DONE SHALL be ignored.
REQ-020 READ and WRITE both high in IDLE SHALL be ignored: BUSYWAIT stays low, the state stays IDLE, and memory is unchanged.
REQ-021 A read in DONE SHALL return data committed by an immediately preceding write to the same address.

Reset
REQ-022 When RESET is high at an edge, the state SHALL go to IDLE, the counter SHALL be 0 and READDATA SHALL be 8'h00.
REQ-023 While RESET is high, BUSYWAIT SHALL be low regardless of READ or WRITE.
REQ-024 Reset during ACCESS SHALL abort the transaction: a pending write SHALL NOT commit, and READDATA SHALL be 8'h00.
REQ-025 Memory array contents SHALL be unaffected by reset.

Structure
REQ-026 Package data_mem_pkg SHALL hold the state enumeration (IDLE, ACCESS, DONE), the ACCESS_CYCLES default and the DEPTH default.
REQ-027 The latency counter SHALL be a sub-module mem_latency_counter with ports: clear, enable, 4-bit count and terminal-count flag.
REQ-028 The memory array and the FSM SHALL reside in data_memory.

Verification
REQ-029 Write at ADDRESS=8'h10, WRITEDATA=8'hA5, followed by a read of 8'h10 -> each access stalls for 6 cycles, and READDATA=8'hA5 in the read's DONE cycle.
REQ-030 READ held high for 10 cycles on ADDRESS=8'h03 -> exactly one transaction occurs, BUSYWAIT is high for 6 cycles then low for 1 DONE cycle, and a new transaction starts only when READ is still high in IDLE.
REQ-031 Write 8'h5A to 8'h20, with RESET pulsed in the 3rd ACCESS cycle, then read 8'h20 -> the read returns the prior content (8'h00 after initialization), READDATA=8'h00 after reset, and BUSYWAIT is low in the reset cycle.
REQ-032 READ=WRITE=1 at ADDRESS=8'h07 -> BUSYWAIT stays 0, state stays IDLE, and mem[8'h07] is unchanged.
REQ-033 ADDRESS changed from 8'h04 to 8'h05 during ACCESS of a read -> READDATA equals mem[8'h04].
REQ-034 Write 8'hFF to 8'hFF (top address), then read 8'hFF and 8'h00 -> READDATA is 8'hFF and then 8'h00, confirming no address wrap corruption.
